// File: rtl/text_pkg.sv
// Shared constants and state encoding for the text cursor controller.
package text_pkg;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_BS    = 8'h08;
  localparam logic [7:0] ASCII_FF    = 8'h0C;

  localparam logic [7:0] ASCII_PRINT_LO = 8'h20;
  localparam logic [7:0] ASCII_PRINT_HI = 8'h7E;

  localparam logic STATE_IDLE  = 1'b0;
  localparam logic STATE_CLEAR = 1'b1;

  typedef enum logic {
    IDLE  = STATE_IDLE,
    CLEAR = STATE_CLEAR
  } state_t;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= ASCII_PRINT_LO) && (b <= ASCII_PRINT_HI);
  endfunction

endpackage

// File: rtl/strobe_edge_detect.sv
// Rising-edge detector for level strobes; rise is combinational on the current input.
module strobe_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic rise
);

  logic in_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) in_q <= 1'b0;
    else        in_q <= in;
  end

  assign rise = in & ~in_q;

endmodule

// File: rtl/text_cursor_ctrl.sv
// UART byte to text-RAM writer with cursor tracking and a clear sweep.
// Control-code decode (CR/LF/BS/FF) is enabled by defining CTRL_CHAR_EN.
//
// state | meaning
// IDLE  | waiting for an accepted byte; decodes it into a write and/or cursor move
// CLEAR | writes a space to one cell per cycle, row-major; incoming bytes are dropped
module text_cursor_ctrl
  import text_pkg::*;
#(
  parameter int COLS  = 32,
  parameter int ROWS  = 4,
  parameter int COL_W = $clog2(COLS),
  parameter int ROW_W = $clog2(ROWS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             wr_en,
  output logic [ROW_W-1:0] wr_row,
  output logic [COL_W-1:0] wr_col,
  output logic [7:0]       wr_data,
  output logic [ROW_W-1:0] cur_row,
  output logic [COL_W-1:0] cur_col,
  output logic             busy,
  output logic             drop
);

  localparam int CELL_W = ROW_W + COL_W;
  localparam logic [CELL_W-1:0] LAST_CELL = CELL_W'(COLS * ROWS - 1);
  localparam logic [CELL_W-1:0] ONE_CELL  = CELL_W'(1);

  // Cursor and addresses are kept as a linear {row, col} cell index so the
  // power-of-two wrap rules fall out of plain binary add/subtract.
  state_t            state_q, state_d;
  logic [CELL_W-1:0] idx_q, idx_d;
  logic [CELL_W-1:0] cur_q, cur_d;
  logic [CELL_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              wr_en_q, wr_en_d;
  logic              busy_q, busy_d;
  logic              drop_q, drop_d;
  logic              accept;

  strobe_edge_detect u_rx_edge (
    .clk   (clk),
    .reset (reset),
    .in    (rx_valid),
    .rise  (accept)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= CLEAR;
      idx_q     <= '0;
      cur_q     <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cur_q     <= cur_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_en_q   <= wr_en_d;
      busy_q    <= busy_d;
      drop_q    <= drop_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cur_d     = cur_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_en_d   = 1'b0;
    busy_d    = 1'b0;
    drop_d    = 1'b0;
    case (state_q)
      CLEAR: begin
        wr_en_d   = 1'b1;
        busy_d    = 1'b1;
        wr_addr_d = idx_q;
        wr_data_d = ASCII_SPACE;
        idx_d     = idx_q + ONE_CELL;
        drop_d    = accept;
        if (idx_q == LAST_CELL) state_d = IDLE;
      end
      IDLE: begin
        if (accept) begin
`ifdef CTRL_CHAR_EN
          case (rx_data)
            ASCII_CR: cur_d = {cur_q[CELL_W-1:COL_W], {COL_W{1'b0}}};
            ASCII_LF: cur_d = cur_q + CELL_W'(COLS);
            ASCII_BS: begin
              if (cur_q != '0) begin
                cur_d     = cur_q - ONE_CELL;
                wr_en_d   = 1'b1;
                wr_addr_d = cur_q - ONE_CELL;
                wr_data_d = ASCII_SPACE;
              end
            end
            ASCII_FF: begin
              // The first sweep write is issued here so busy and wr_en line up
              // for exactly COLS*ROWS cycles, as after reset.
              state_d   = CLEAR;
              cur_d     = '0;
              wr_en_d   = 1'b1;
              busy_d    = 1'b1;
              wr_addr_d = '0;
              wr_data_d = ASCII_SPACE;
              idx_d     = ONE_CELL;
            end
            default: begin
              if (is_printable(rx_data)) begin
                wr_en_d   = 1'b1;
                wr_addr_d = cur_q;
                wr_data_d = rx_data;
                cur_d     = cur_q + ONE_CELL;
              end
            end
          endcase
`else
          wr_en_d   = 1'b1;
          wr_addr_d = cur_q;
          wr_data_d = rx_data;
          cur_d     = cur_q + ONE_CELL;
`endif
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  assign wr_en   = wr_en_q;
  assign wr_row  = wr_addr_q[CELL_W-1:COL_W];
  assign wr_col  = wr_addr_q[COL_W-1:0];
  assign wr_data = wr_data_q;
  assign cur_row = cur_q[CELL_W-1:COL_W];
  assign cur_col = cur_q[COL_W-1:0];
  assign busy    = busy_q;
  assign drop    = drop_q;

endmodule

// File: tb/tb_text_cursor_ctrl.sv
// Scoreboard bench for text_cursor_ctrl; covers both CTRL_CHAR_EN builds.
module tb_text_cursor_ctrl;

  logic       clk;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       wr_en;
  logic [1:0] wr_row;
  logic [4:0] wr_col;
  logic [7:0] wr_data;
  logic [1:0] cur_row;
  logic [4:0] cur_col;
  logic       busy;
  logic       drop;

  text_cursor_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .wr_en    (wr_en),
    .wr_row   (wr_row),
    .wr_col   (wr_col),
    .wr_data  (wr_data),
    .cur_row  (cur_row),
    .cur_col  (cur_col),
    .busy     (busy),
    .drop     (drop)
  );

  typedef struct packed {
    logic [1:0] row;
    logic [4:0] col;
    logic [7:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  vectors = 0;
  int  fails = 0;
  int  drops_seen = 0;
  int  exp_drops = 0;
  int  run_len = 0;
  int  last_run = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic check(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endtask

  task automatic check_cur(input string nm, input int r, input int c);
    check({nm, "_row"}, int'(cur_row), r);
    check({nm, "_col"}, int'(cur_col), c);
  endtask

  task automatic push_wr(input int pos, input logic [7:0] d);
    wr_t e;
    e.row  = 2'(pos / 32);
    e.col  = 5'(pos % 32);
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic push_sweep();
    for (int i = 0; i < 128; i++) push_wr(i, 8'h20);
  endtask

  task automatic send(input logic [7:0] b, input int hold);
    rx_data  = b;
    rx_valid = 1'b1;
    repeat (hold) @(negedge clk);
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_idle(input string nm);
    int g = 0;
    while (!busy && g < 5) begin @(negedge clk); g++; end
    while (busy && g < 400) begin @(negedge clk); g++; end
    check({nm, "_done"}, int'(busy), 0);
    @(negedge clk);
    check({nm, "_busy_len"}, last_run, 128);
  endtask

  // Monitor: pops one expected write per observed wr_en and tracks busy/drop.
  initial begin
    forever begin
      @(negedge clk);
      if (wr_en) begin
        vectors++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_write: got row %0d col %0d data %h, required no write",
                   wr_row, wr_col, wr_data);
        end else begin
          mon_e = exp_q.pop_front();
          if (wr_row !== mon_e.row || wr_col !== mon_e.col || wr_data !== mon_e.data) begin
            fails++;
            $display("FAIL write: got (%0d,%0d)=%h, required (%0d,%0d)=%h",
                     wr_row, wr_col, wr_data, mon_e.row, mon_e.col, mon_e.data);
          end
        end
      end
      if (drop) drops_seen++;
      if (busy) run_len++;
      else if (run_len > 0) begin
        last_run = run_len;
        run_len  = 0;
      end
    end
  end

  initial begin
    reset    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_wr_en", int'(wr_en), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_drop", int'(drop), 0);
    check_cur("rst_cur", 0, 0);

    // Post-reset sweep
    push_sweep();
    reset = 1'b1;
    wait_idle("init_sweep");
    check_cur("init_sweep_cur", 0, 0);

    // Single 'A' with a long strobe
    push_wr(0, 8'h41);
    send(8'h41, 5);
    check_cur("a_cur", 0, 1);

    // Fill to the last cell, wrap, then write at (0,0)
    for (int i = 0; i < 127; i++) begin
      push_wr(1 + i, 8'(8'h21 + (i % 90)));
      send(8'(8'h21 + (i % 90)), 1);
    end
    check_cur("wrap_cur", 0, 0);
    push_wr(0, 8'h7E);
    send(8'h7E, 1);
    check_cur("after_wrap_cur", 0, 1);

`ifdef CTRL_CHAR_EN
    // Backspace across a row boundary, then at home
    for (int i = 1; i < 32; i++) begin
      push_wr(i, 8'h61);
      send(8'h61, 1);
    end
    check_cur("row1_cur", 1, 0);
    push_wr(31, 8'h20);
    send(8'h08, 1);
    check_cur("bs_cur", 0, 31);
    send(8'h0D, 1);
    check_cur("cr_home_cur", 0, 0);
    send(8'h08, 1);
    check_cur("bs_home_cur", 0, 0);
    send(8'h7F, 1);
    send(8'h80, 2);
    send(8'h1F, 1);
    send(8'h00, 1);
    check_cur("ignored_cur", 0, 0);

    // CR / LF moves without writes
    send(8'h0A, 1);
    send(8'h0A, 1);
    for (int i = 0; i < 7; i++) begin
      push_wr(64 + i, 8'(8'h20 + i));
      send(8'(8'h20 + i), 1);
    end
    check_cur("pos27_cur", 2, 7);
    send(8'h0D, 1);
    check_cur("cr_cur", 2, 0);
    send(8'h0A, 1);
    check_cur("lf_cur", 3, 0);
    send(8'h0A, 1);
    check_cur("lf_wrap_cur", 0, 0);

    // Form feed: sweep, drop during sweep, cursor home
    push_wr(0, 8'h5A);
    send(8'h5A, 1);
    check_cur("pre_ff_cur", 0, 1);
    push_sweep();
    rx_data  = 8'h0C;
    rx_valid = 1'b1;
    @(negedge clk);
    check("ff_busy", int'(busy), 1);
    check_cur("ff_cur", 0, 0);
    rx_valid = 1'b0;
    repeat (9) @(negedge clk);
    exp_drops++;
    send(8'h41, 1);
    wait_idle("ff_sweep");
    check_cur("ff_end_cur", 0, 0);
`else
    // Control codes are written literally
    push_wr(1, 8'h08);
    send(8'h08, 1);
    push_wr(2, 8'h0D);
    send(8'h0D, 1);
    push_wr(3, 8'h0A);
    send(8'h0A, 1);
    push_wr(4, 8'h0C);
    send(8'h0C, 1);
    check("ff_literal_busy", int'(busy), 0);
    push_wr(5, 8'h00);
    send(8'h00, 1);
    push_wr(6, 8'hFF);
    send(8'hFF, 2);
    check_cur("literal_cur", 0, 7);
`endif

    // Reset mid-sweep restarts from (0,0); byte during sweep is dropped
    reset = 1'b0;
    #1;
    exp_q.delete();
    push_sweep();
    repeat (2) @(negedge clk);
    check("rst2_wr_en", int'(wr_en), 0);
    check_cur("rst2_cur", 0, 0);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    exp_drops++;
    send(8'h55, 1);
    repeat (20) @(negedge clk);
    reset = 1'b0;
    #1;
    exp_q.delete();
    push_sweep();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    wait_idle("restart_sweep");
    check_cur("restart_cur", 0, 0);
    push_wr(0, 8'h42);
    send(8'h42, 1);
    check_cur("post_restart_cur", 0, 1);

    repeat (4) @(negedge clk);
    check("pending_writes", exp_q.size(), 0);
    check("drop_count", drops_seen, exp_drops);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
